gc_remap_responder: RTL

Remapping-table side of the garbage-collection interface: tracks per-block state and valid-page counts, assigns physical pages to host writes in the active block, reports fully-invalid blocks to the GC engine, and executes GC move/erase commands. Sits between the host write path and the GC engine (`gc` modport). Drives `invalid_blk`/`invalid_flag`, `move_done_flag` and `active_request`; consumes `erase_blk`, `active_blk` and `move_flag`.

---
 rtl/NVM_pkg.sv | 22 ++
 rtl/gc_invalid_scan.sv | 23 ++
 rtl/gc_remap_responder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/NVM_pkg.sv
// Shared types for the GC remapping table: block index, per-block state and move FSM encoding.
package NVM_pkg;

  localparam int NUM_BLK_DEF       = 16;
  localparam int PAGES_PER_BLK_DEF = 8;
  localparam int BLK_W             = $clog2(NUM_BLK_DEF);

  typedef logic [BLK_W-1:0] block_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    ACTIVE = 2'd1,
    USED   = 2'd2
  } blk_state_t;

  typedef enum logic [1:0] {
    MV_IDLE = 2'd0,
    MV_MOVE = 2'd1,
    MV_DONE = 2'd2
  } move_state_t;

endpackage

// File: rtl/gc_invalid_scan.sv
// Lowest-index priority encoder over the "USED with zero valid pages" candidate vector.
module gc_invalid_scan
  import NVM_pkg::*;
#(
  parameter int NUM_BLK = NUM_BLK_DEF
) (
  input  logic [NUM_BLK-1:0] cand,
  output block_t             blk,
  output logic               found
);

  always_comb begin
    blk   = '0;
    found = 1'b0;
    for (int i = NUM_BLK - 1; i >= 0; i--) begin
      if (cand[i]) begin
        blk   = block_t'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gc_remap_responder.sv
// Remapping-table side of the GC interface: block states, valid-page counts, host page allocation
// and move/erase execution. Optional GC_WEAR_COUNT_EN adds per-block erase counters and erase_cnt.
module gc_remap_responder
  import NVM_pkg::*;
#(
  parameter int NUM_BLK       = NUM_BLK_DEF,
  parameter int PAGES_PER_BLK = PAGES_PER_BLK_DEF
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic                                      write_en,
  output logic                                      write_ready,
  output logic [$clog2(NUM_BLK*PAGES_PER_BLK)-1:0]  write_ppa,
  input  logic                                      inv_en,
  input  block_t                                    inv_blk,
  input  block_t                                    erase_blk,
  input  block_t                                    active_blk,
  input  logic                                      move_flag,
  output block_t                                    invalid_blk,
  output logic                                      invalid_flag,
  output logic                                      move_done_flag,
`ifdef GC_WEAR_COUNT_EN
  output logic [7:0]                                erase_cnt,
`endif
  output logic                                      active_request
);

  localparam int PW = $clog2(PAGES_PER_BLK);
  localparam int CW = PW + 1;

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t PAGES = cnt_t'(PAGES_PER_BLK);

  blk_state_t  blk_state [NUM_BLK];
  cnt_t        valid_cnt [NUM_BLK];
  cnt_t        cnt_nxt   [NUM_BLK];
  block_t      cur_act;
  cnt_t        ptr;
  move_state_t mv_state;
  move_state_t mv_next;
  block_t      src;
  logic        src_used;

  logic               wr_acc;
  logic               move_step;
  logic               adopt;
  logic               erase_now;
  logic [NUM_BLK-1:0] cand;
  block_t             scan_blk;
  logic               scan_found;

  // Add at most one page, remove up to two, never drop below zero.
  function automatic cnt_t upd_cnt(input cnt_t cnt, input logic inc, input logic [1:0] dec);
    logic [CW:0] sum;
    logic [CW:0] sub;
    sum = {1'b0, cnt} + {{CW{1'b0}}, inc};
    sub = {{(CW-1){1'b0}}, dec};
    if (sum <= sub) return '0;
    return cnt_t'(sum - sub);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Output / handshake decode
  always_comb begin
    write_ready    = (mv_state == MV_IDLE) && (ptr < PAGES);
    active_request = (ptr == PAGES);
    write_ppa      = {cur_act, ptr[PW-1:0]};
    move_done_flag = (mv_state == MV_DONE);
    wr_acc         = write_en && write_ready;
    move_step      = (mv_state == MV_MOVE) && (ptr < PAGES) && (valid_cnt[src] != '0);
    adopt          = active_request && (active_blk != cur_act) && (blk_state[active_blk] == FREE);
    erase_now      = (mv_state == MV_DONE) && src_used;
  end

  always_comb begin
    for (int i = 0; i < NUM_BLK; i++) begin
      cnt_nxt[i] = upd_cnt(valid_cnt[i],
                           (wr_acc || move_step) && (cur_act == block_t'(i)),
                           {1'b0, inv_en && (inv_blk == block_t'(i))} +
                           {1'b0, move_step && (src == block_t'(i))});
      if (erase_now && (src == block_t'(i))) cnt_nxt[i] = '0;
      cand[i] = (blk_state[i] == USED) && (valid_cnt[i] == '0);
    end
  end

  // Move FSM next state
  always_comb begin
    mv_next = mv_state;
    case (mv_state)
      MV_IDLE: if (move_flag)
                 mv_next = ((blk_state[erase_blk] == USED) && (valid_cnt[erase_blk] != '0))
                           ? MV_MOVE : MV_DONE;
      MV_MOVE: if (cnt_nxt[src] == '0) mv_next = MV_DONE;
      MV_DONE: mv_next = MV_IDLE;
      default: mv_next = MV_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) mv_state <= MV_IDLE;
    else     mv_state <= mv_next;
  end

  always_ff @(posedge CLK) begin
    if ((mv_state == MV_IDLE) && move_flag) begin
      src      <= erase_blk;
      src_used <= (blk_state[erase_blk] == USED);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_BLK; i++) begin
        blk_state[i] <= FREE;
        valid_cnt[i] <= '0;
      end
      blk_state[0] <= ACTIVE;
      cur_act      <= '0;
      ptr          <= '0;
    end else begin
      for (int i = 0; i < NUM_BLK; i++) valid_cnt[i] <= cnt_nxt[i];
      if (wr_acc || move_step) ptr <= ptr + cnt_t'(1);
      // adoption only happens with a full pointer, so it never races a page step
      if (adopt) begin
        blk_state[cur_act]    <= USED;
        blk_state[active_blk] <= ACTIVE;
        cur_act               <= active_blk;
        ptr                   <= '0;
      end
      if (erase_now) blk_state[src] <= FREE;
    end
  end

  gc_invalid_scan #(.NUM_BLK(NUM_BLK)) u_scan (
    .cand  (cand),
    .blk   (scan_blk),
    .found (scan_found)
  );

`ifdef GC_WEAR_COUNT_EN
  logic [7:0] wear [NUM_BLK];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_BLK; i++) wear[i] <= '0;
    end else if (erase_now) begin
      wear[src] <= sat_inc8(wear[src]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      invalid_flag <= 1'b0;
      invalid_blk  <= '0;
      erase_cnt    <= '0;
    end else begin
      invalid_flag <= scan_found;
      invalid_blk  <= scan_blk;
      erase_cnt    <= wear[scan_blk];
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (RST) begin
      invalid_flag <= 1'b0;
      invalid_blk  <= '0;
    end else begin
      invalid_flag <= scan_found;
      invalid_blk  <= scan_blk;
    end
  end
`endif

endmodule
